// File: rtl/uart_tx_arbiter.sv
// Purpose : shares one UART transmitter between two byte sources (A, B) with per-port FIFOs and message-locked round robin.
// Latency : strobe at n -> byte popped and granted at n+1 -> tx_start at n+2; byte period >= 4 cycles plus transmitter busy time.
// Backpress: per-port registered full flag; a strobe while full drops the byte and sets a sticky overflow bit.
module uart_tx_arbiter #(
    parameter int         DEPTH        = 4,
    parameter logic [7:0] LOCK_CHAR    = 8'h0A,
    parameter int         MAX_BURST    = 64,
    parameter int         LOCK_TIMEOUT = 4095,
    parameter int         BUSY_TIMEOUT = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] a_data,
    input  logic       a_strobe,
    output logic       a_full,
    input  logic [7:0] b_data,
    input  logic       b_strobe,
    output logic       b_full,
    output logic [7:0] tx_data,
    output logic       tx_start,
    input  logic       tx_busy,
    output logic [1:0] grant,
    output logic [1:0] ovf
);

    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW  = AW + 1;
    localparam int BW  = $clog2(MAX_BURST + 1);
    localparam int IW  = $clog2(LOCK_TIMEOUT + 1);
    localparam int TW  = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        START   = 2'd1,
        WAIT_HI = 2'd2,
        WAIT_LO = 2'd3
    } state_t;

    // Per-port FIFO view, index 0 = port A, index 1 = port B.
    logic [1:0]      wr_stb;
    logic [1:0][7:0] wr_dat;
    logic [1:0]      pop;
    logic [1:0]      empty;
    logic [1:0]      full;
    logic [1:0]      ovf_bit;
    logic [1:0][7:0] head;

    assign wr_stb = {b_strobe, a_strobe};
    assign wr_dat = {b_data, a_data};

    for (genvar p = 0; p < 2; p++) begin : g_fifo
        logic [7:0]    mem_q [DEPTH];
        logic [AW-1:0] wr_ptr_q;
        logic [AW-1:0] rd_ptr_q;
        logic [CW-1:0] cnt_q;
        logic [CW-1:0] cnt_d;
        logic          full_q;
        logic          ovf_q;
        logic          wr_en;
        logic          rd_en;

        // full is the registered flag, so a write racing a pop on a full FIFO is still dropped
        assign wr_en = wr_stb[p] && !full_q;
        assign rd_en = pop[p] && (cnt_q != '0);

        // occupancy after this cycle's write/pop
        always_comb begin
            cnt_d = cnt_q;
            if (wr_en && !rd_en) begin
                cnt_d = cnt_q + 1'b1;
            end else if (rd_en && !wr_en) begin
                cnt_d = cnt_q - 1'b1;
            end
        end

        // pointers, count, full flag and sticky overflow; pointers wrap naturally at DEPTH
        always_ff @(posedge clk) begin
            if (rst) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                cnt_q    <= '0;
                full_q   <= 1'b0;
                ovf_q    <= 1'b0;
            end else begin
                if (wr_en) begin
                    wr_ptr_q <= wr_ptr_q + 1'b1;
                end
                if (rd_en) begin
                    rd_ptr_q <= rd_ptr_q + 1'b1;
                end
                cnt_q  <= cnt_d;
                full_q <= (cnt_d == CW'(DEPTH));
                if (wr_stb[p] && full_q) begin
                    ovf_q <= 1'b1;
                end
            end
        end

        // byte storage; contents are don't-care while the count says empty
        always_ff @(posedge clk) begin
            if (wr_en) begin
                mem_q[wr_ptr_q] <= wr_dat[p];
            end
        end

        assign empty[p]   = (cnt_q == '0);
        assign full[p]    = full_q;
        assign ovf_bit[p] = ovf_q;
        assign head[p]    = mem_q[rd_ptr_q];
    end

    state_t        state_q, state_d;
    logic [1:0]    grant_q, grant_d;
    logic          last_q, last_d;        // 0: A granted last, 1: B granted last
    logic [7:0]    tx_data_q, tx_data_d;
    logic [BW-1:0] burst_q, burst_d;
    logic [BW-1:0] burst_inc;
    logic [IW-1:0] idle_q, idle_d;
    logic [TW-1:0] busy_cnt_q, busy_cnt_d;
    logic          serve_a;
    logic          serve_b;

    // A port is served when it has data and either owns the lock, or the arbiter is
    // unlocked and the port wins: sole requester, or the one not granted last on a tie.
    assign serve_a = (state_q == IDLE) && !empty[0] &&
                     ((grant_q == 2'b01) || ((grant_q == 2'b00) && (empty[1] || last_q)));
    assign serve_b = (state_q == IDLE) && !empty[1] &&
                     ((grant_q == 2'b10) || ((grant_q == 2'b00) && (empty[0] || !last_q)));

    assign burst_inc = burst_q + 1'b1;

    // next-state: scheduling in IDLE, transmitter handshake, lock release on return to IDLE
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_d     = last_q;
        tx_data_d  = tx_data_q;
        burst_d    = burst_q;
        idle_d     = idle_q;
        busy_cnt_d = busy_cnt_q;
        pop        = 2'b00;

        case (state_q)
            IDLE: begin
                if (serve_a) begin
                    pop[0]    = 1'b1;
                    tx_data_d = head[0];
                    idle_d    = '0;
                    state_d   = START;
                    if (grant_q == 2'b00) begin
                        grant_d = 2'b01;
                        last_d  = 1'b0;
                        burst_d = '0;
                    end
                end else if (serve_b) begin
                    pop[1]    = 1'b1;
                    tx_data_d = head[1];
                    idle_d    = '0;
                    state_d   = START;
                    if (grant_q == 2'b00) begin
                        grant_d = 2'b10;
                        last_d  = 1'b1;
                        burst_d = '0;
                    end
                end else if (grant_q != 2'b00) begin
                    // owner has nothing queued: drop a stale lock after LOCK_TIMEOUT idle cycles
                    if (idle_q == IW'(LOCK_TIMEOUT - 1)) begin
                        grant_d = 2'b00;
                        idle_d  = '0;
                    end else begin
                        idle_d = idle_q + 1'b1;
                    end
                end
            end
            START: begin
                busy_cnt_d = '0;
                state_d    = WAIT_HI;
            end
            WAIT_HI: begin
                // a transmitter that never raises busy is assumed to have taken the byte
                if (tx_busy) begin
                    state_d = WAIT_LO;
                end else if (busy_cnt_q == TW'(BUSY_TIMEOUT - 1)) begin
                    state_d = WAIT_LO;
                end else begin
                    busy_cnt_d = busy_cnt_q + 1'b1;
                end
            end
            WAIT_LO: begin
                if (!tx_busy) begin
                    state_d = IDLE;
                    burst_d = burst_inc;
                    if ((tx_data_q == LOCK_CHAR) || (burst_inc == BW'(MAX_BURST))) begin
                        grant_d = 2'b00;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // scheduler state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_q    <= 2'b00;
            last_q     <= 1'b0;
            tx_data_q  <= 8'h00;
            burst_q    <= '0;
            idle_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            tx_data_q  <= tx_data_d;
            burst_q    <= burst_d;
            idle_q     <= idle_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign tx_start = (state_q == START);
    assign tx_data  = tx_data_q;
    assign grant    = grant_q;
    assign a_full   = full[0];
    assign b_full   = full[1];
    assign ovf      = ovf_bit;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Purpose : directed bench for uart_tx_arbiter with a simple transmitter busy model.
// Latency : inputs driven 1 time unit after posedge, outputs sampled at negedge.
// Backpress: transmitter busy is either pulsed for busy_len cycles per tx_start or forced high.
module tb_uart_tx_arbiter;

    logic       clk;
    logic       rst;
    logic [7:0] a_data;
    logic       a_strobe;
    logic       a_full;
    logic [7:0] b_data;
    logic       b_strobe;
    logic       b_full;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
    logic [1:0] grant;
    logic [1:0] ovf;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int  busy_len   = 0;
    bit  force_busy = 1'b0;
    int  rem        = 0;

    logic [7:0] q_dat [$];
    logic [1:0] q_gnt [$];
    int         q_cyc [$];

    uart_tx_arbiter #(
        .DEPTH       (4),
        .LOCK_CHAR   (8'h0A),
        .MAX_BURST   (3),
        .LOCK_TIMEOUT(8),
        .BUSY_TIMEOUT(7)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .a_data  (a_data),
        .a_strobe(a_strobe),
        .a_full  (a_full),
        .b_data  (b_data),
        .b_strobe(b_strobe),
        .b_full  (b_full),
        .tx_data (tx_data),
        .tx_start(tx_start),
        .tx_busy (tx_busy),
        .grant   (grant),
        .ovf     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // transmitter model: busy high for busy_len negedge-to-negedge periods starting in the START cycle
    always @(negedge clk) begin
        if (force_busy) begin
            tx_busy = 1'b1;
            rem     = 0;
        end else begin
            if (tx_start === 1'b1) rem = busy_len;
            tx_busy = (rem > 0);
            if (rem > 0) rem--;
        end
    end

    // record every send with its owner and cycle
    always @(negedge clk) begin
        if (tx_start === 1'b1) begin
            q_dat.push_back(tx_data);
            q_gnt.push_back(grant);
            q_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] dat_at(input int i);
        return (i < q_dat.size()) ? 32'(q_dat[i]) : 32'hDEAD;
    endfunction

    function automatic logic [31:0] gnt_at(input int i);
        return (i < q_gnt.size()) ? 32'(q_gnt[i]) : 32'hDEAD;
    endfunction

    function automatic int cyc_at(input int i);
        return (i < q_cyc.size()) ? q_cyc[i] : -1000;
    endfunction

    task automatic exp_send(input string tag, input int i, input logic [31:0] d, input logic [31:0] g);
        chk($sformatf("%s[%0d].dat", tag, i), dat_at(i), d);
        chk($sformatf("%s[%0d].gnt", tag, i), gnt_at(i), g);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // one cycle of producer stimulus
    task automatic drive(input bit as, input logic [7:0] ad, input bit bs, input logic [7:0] bd);
        a_strobe = as;
        a_data   = ad;
        b_strobe = bs;
        b_data   = bd;
        @(posedge clk);
        #1;
        a_strobe = 1'b0;
        b_strobe = 1'b0;
    endtask

    task automatic do_reset;
        force_busy = 1'b1;
        a_strobe   = 1'b0;
        b_strobe   = 1'b0;
        rst        = 1'b1;
        idle(2);
        rst = 1'b0;
        q_dat.delete();
        q_gnt.delete();
        q_cyc.delete();
        force_busy = 1'b0;
    endtask

    // wait for n sends within budget cycles, then let it settle and confirm no extra sends
    task automatic wait_sends(input int n, input int budget, input int settle, input string tag);
        int k;
        k = 0;
        while (q_dat.size() < n && k < budget) begin
            idle(1);
            k++;
        end
        idle(settle);
        chk({tag, ".count"}, 32'(q_dat.size()), 32'(n));
    endtask

    initial begin
        int t0;
        int s;
        rst      = 1'b1;
        a_data   = 8'h00;
        a_strobe = 1'b0;
        b_data   = 8'h00;
        b_strobe = 1'b0;
        tx_busy  = 1'b0;
        do_reset();

        // reset state
        chk("rst.tx_start", 32'(tx_start), 0);
        chk("rst.tx_data",  32'(tx_data),  0);
        chk("rst.grant",    32'(grant),    0);
        chk("rst.a_full",   32'(a_full),   0);
        chk("rst.b_full",   32'(b_full),   0);
        chk("rst.ovf",      32'(ovf),      0);

        // basic send, busy high for 10 cycles from START
        busy_len = 10;
        t0 = cyc;
        drive(1'b1, 8'h41, 1'b0, 8'h00);
        wait_sends(1, 50, 0, "basic");
        s = cyc_at(0);
        chk("basic.latency", 32'(s - t0), 2);
        exp_send("basic", 0, 'h41, 1);
        while (cyc < s + 10 && cyc < t0 + 200) idle(1);
        chk("basic.wait_lo", 32'(dut.state_q), 3);
        idle(1);
        chk("basic.idle", 32'(dut.state_q), 0);
        chk("basic.locked", 32'(grant), 1);
        idle(30);
        chk("basic.lock_timeout", 32'(grant), 0);

        // lock: "HI\n" from A, B queues 'X' after 'H'
        do_reset();
        busy_len = 2;
        drive(1'b1, 8'h48, 1'b0, 8'h00);
        drive(1'b1, 8'h49, 1'b1, 8'h58);
        drive(1'b1, 8'h0A, 1'b0, 8'h00);
        wait_sends(4, 300, 30, "lock");
        exp_send("lock", 0, 'h48, 1);
        exp_send("lock", 1, 'h49, 1);
        exp_send("lock", 2, 'h0A, 1);
        exp_send("lock", 3, 'h58, 2);

        // LOCK_CHAR alone (burst 2 < MAX_BURST) releases the grant and B wins the tie
        do_reset();
        busy_len = 2;
        drive(1'b1, 8'h5A, 1'b0, 8'h00);
        drive(1'b1, 8'h0A, 1'b1, 8'h52);
        drive(1'b1, 8'h51, 1'b0, 8'h00);
        wait_sends(4, 300, 30, "lchar");
        exp_send("lchar", 0, 'h5A, 1);
        exp_send("lchar", 1, 'h0A, 1);
        exp_send("lchar", 2, 'h52, 2);
        exp_send("lchar", 3, 'h51, 1);

        // tie after reset: B first, then A after B's lock times out
        do_reset();
        busy_len = 2;
        drive(1'b1, 8'h31, 1'b1, 8'h32);
        wait_sends(2, 300, 30, "tie");
        exp_send("tie", 0, 'h32, 2);
        exp_send("tie", 1, 'h31, 1);

        // overflow: B's byte holds the transmitter busy while A is strobed 5 times
        do_reset();
        force_busy = 1'b1;
        drive(1'b0, 8'h00, 1'b1, 8'h55);
        idle(4);
        drive(1'b1, 8'h61, 1'b0, 8'h00);
        drive(1'b1, 8'h62, 1'b0, 8'h00);
        drive(1'b1, 8'h63, 1'b0, 8'h00);
        chk("ovf.full_after3", 32'(a_full), 0);
        drive(1'b1, 8'h64, 1'b0, 8'h00);
        chk("ovf.full_after4", 32'(a_full), 1);
        chk("ovf.clear_before5", 32'(ovf), 0);
        drive(1'b1, 8'h65, 1'b0, 8'h00);
        chk("ovf.set", 32'(ovf), 1);
        chk("ovf.still_full", 32'(a_full), 1);
        busy_len   = 3;
        force_busy = 1'b0;
        wait_sends(5, 400, 40, "ovf");
        exp_send("ovf", 0, 'h55, 2);
        exp_send("ovf", 1, 'h61, 1);
        exp_send("ovf", 2, 'h62, 1);
        exp_send("ovf", 3, 'h63, 1);
        exp_send("ovf", 4, 'h64, 1);
        chk("ovf.sticky", 32'(ovf), 1);
        chk("ovf.a_full_end", 32'(a_full), 0);
        chk("ovf.b_full_end", 32'(b_full), 0);

        // busy never rises: START + 7 WAIT_HI + WAIT_LO + the IDLE pop cycle between starts
        do_reset();
        busy_len = 0;
        drive(1'b1, 8'h71, 1'b0, 8'h00);
        drive(1'b1, 8'h72, 1'b0, 8'h00);
        wait_sends(2, 100, 30, "bto");
        chk("bto.gap", 32'(cyc_at(1) - cyc_at(0)), 10);
        exp_send("bto", 1, 'h72, 1);

        // MAX_BURST = 3: A x3, B x1, A x2
        do_reset();
        busy_len = 2;
        drive(1'b1, 8'h11, 1'b0, 8'h00);
        drive(1'b1, 8'h12, 1'b1, 8'h42);
        drive(1'b1, 8'h13, 1'b0, 8'h00);
        drive(1'b1, 8'h14, 1'b0, 8'h00);
        drive(1'b1, 8'h15, 1'b0, 8'h00);
        wait_sends(6, 600, 40, "burst");
        exp_send("burst", 0, 'h11, 1);
        exp_send("burst", 1, 'h12, 1);
        exp_send("burst", 2, 'h13, 1);
        exp_send("burst", 3, 'h42, 2);
        exp_send("burst", 4, 'h14, 1);
        exp_send("burst", 5, 'h15, 1);

        // reset mid-operation discards queued bytes and clears flags
        do_reset();
        force_busy = 1'b1;
        for (int i = 0; i < 6; i++) drive(1'b1, 8'(8'h81 + i), 1'b0, 8'h00);
        chk("mrst.pre_full", 32'(a_full), 1);
        chk("mrst.pre_ovf", 32'(ovf), 1);
        rst = 1'b1;
        idle(1);
        chk("mrst.tx_start", 32'(tx_start), 0);
        chk("mrst.grant", 32'(grant), 0);
        chk("mrst.tx_data", 32'(tx_data), 0);
        chk("mrst.a_full", 32'(a_full), 0);
        chk("mrst.ovf", 32'(ovf), 0);
        rst = 1'b0;
        q_dat.delete();
        q_gnt.delete();
        q_cyc.delete();
        busy_len   = 3;
        force_busy = 1'b0;
        idle(40);
        chk("mrst.no_send", 32'(q_dat.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
